// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: three requesters share one register-file write port with a one-cycle registered output stage.
// Optional write-to-read bypass is compiled only when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int RR_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    req_valid,
   output logic [2:0]    req_ready,
   input  logic [AW-1:0] req_addr0,
   input  logic [AW-1:0] req_addr1,
   input  logic [AW-1:0] req_addr2,
   input  logic [DW-1:0] req_data0,
   input  logic [DW-1:0] req_data1,
   input  logic [DW-1:0] req_data2,
   input  logic          flush,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   input  logic [DW-1:0] rf_rdata1,
   input  logic [DW-1:0] rf_rdata2,
   output logic [DW-1:0] fwd_rdata1,
   output logic [DW-1:0] fwd_rdata2
);

   logic [1:0]    ptr;
   logic [1:0]    gnt_idx;
   logic [1:0]    idx;
   logic          xfer;
   logic [AW-1:0] gnt_addr;
   logic [DW-1:0] gnt_data;

   function automatic logic [1:0] rot3(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   // Search from the highest offset down so the requester closest to the pointer wins.
   // With fixed priority the pointer never leaves 0, giving req0 > req1 > req2.
   always_comb begin
      req_ready = '0;
      gnt_idx   = 2'd0;
      idx       = 2'd0;
      xfer      = 1'b0;
      if (!rst && !flush) begin
         for (int i = 2; i >= 0; i--) begin
            idx = rot3(ptr, i[1:0]);
            if (req_valid[idx]) begin
               gnt_idx = idx;
               xfer    = 1'b1;
            end
         end
         if (xfer) req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      gnt_addr = req_addr0;
      gnt_data = req_data0;
      case (gnt_idx)
         2'd1: begin
            gnt_addr = req_addr1;
            gnt_data = req_data1;
         end
         2'd2: begin
            gnt_addr = req_addr2;
            gnt_data = req_data2;
         end
         default: begin
            gnt_addr = req_addr0;
            gnt_data = req_data0;
         end
      endcase
   end

   // Writes to register 0 still handshake and advance the pointer, but never strobe rf_we.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         ptr      <= 2'd0;
      end else begin
         rf_we <= xfer && (gnt_addr != '0);
         if (xfer) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
         end
         if (xfer && (RR_EN != 0)) ptr <= rot3(gnt_idx, 2'd1);
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   assign fwd_rdata1 = (rf_we && (raddr1 == rf_waddr) && (raddr1 != '0)) ? rf_wdata : rf_rdata1;
   assign fwd_rdata2 = (rf_we && (raddr2 == rf_waddr) && (raddr2 != '0)) ? rf_wdata : rf_rdata2;
`else
   logic unused_raddr;
   assign unused_raddr = ^{raddr1, raddr2};
   assign fwd_rdata1   = rf_rdata1;
   assign fwd_rdata2   = rf_rdata2;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width.
REQ-002 SHALL have parameter AW, default 5, meaning register address width (32 registers).
REQ-003 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority (req0 > req1 > req2).
REQ-004 SHALL have port clk  input  1  single clock; every state element updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_valid[2:0]  input  3  per-requester write request (0 = ALU, 1 = MDU, 2 = LSU).
REQ-007 SHALL have ports req_ready[2:0]  output  3  per-requester grant; transfer occurs when valid & ready are both high at a rising edge.
REQ-008 SHALL have ports req_addr0..2  input  AW each  destination register per requester.
REQ-009 SHALL have ports req_data0..2  input  DW each  write data per requester.
REQ-010 SHALL have port flush  input  1  kills the output stage and blocks acceptance this cycle.
REQ-011 SHALL have ports rf_we  output  1, rf_waddr  output  AW, rf_wdata  output  DW  registered drive to the register-file write port (rf_we feeds regfilesrc).
REQ-012 SHALL have ports raddr1, raddr2  input  AW; rf_rdata1, rf_rdata2  input  DW; fwd_rdata1, fwd_rdata2  output  DW  read-path values.

Function
REQ-013 SHALL assert at most one req_ready bit per cycle, only for a requester whose req_valid is high; req_ready SHALL be combinational from req_valid, the priority pointer and flush.
REQ-014 SHALL hold all req_ready low while flush = 1; no transfer is accepted in that cycle.
REQ-015 SHALL, with RR_EN = 1, grant the first valid requester searching from the pointer upward modulo 3; after a grant to k the pointer becomes (k+1) mod 3; without a grant the pointer is unchanged.
REQ-016 SHALL, with RR_EN = 0, grant the lowest-index valid requester and never update the pointer.
REQ-017 SHALL load the output stage on the edge of a transfer: rf_waddr/rf_wdata = granted addr/data, and rf_we = 1 unless the granted addr is 0; latency is exactly one cycle from handshake to rf_we.
REQ-018 SHALL complete a handshake to register 0 normally (ready asserted, pointer advances) while the write is dropped (rf_we = 0).
REQ-019 SHALL load rf_we = 0 on any edge with no transfer; rf_waddr/rf_wdata SHALL then hold their previous values.
REQ-020 SHALL load rf_we = 0 on an edge where flush = 1, regardless of req_valid.
REQ-021 SHALL sustain one write per cycle under continuous requests (no bubble between back-to-back grants).
REQ-022 SHALL never grant a requester twice in a row while another requester is valid when RR_EN = 1 (starvation bound: at most 2 cycles of waiting).

Reset
REQ-023 SHALL on rst = 1 at a rising edge set rf_we = 0, rf_waddr = 0, rf_wdata = 0 and pointer = 0.
REQ-024 SHALL hold all req_ready low while rst = 1; a request valid during reset is not accepted and must still be pending afterwards.
REQ-025 SHALL discard an output-stage write in flight when reset arrives (rf_we = 0 on the following cycle).

Configuration
REQ-026 SHALL compile the write-to-read bypass only when macro REGFILE_WB_BYPASS_EN is defined.
REQ-027 SHALL, with REGFILE_WB_BYPASS_EN defined, drive fwd_rdataN = rf_wdata when rf_we = 1 and raddrN == rf_waddr and raddrN != 0, else rf_rdataN (combinational).
REQ-028 SHALL, without REGFILE_WB_BYPASS_EN, drive fwd_rdataN = rf_rdataN unconditionally.

Verification
REQ-029 Bench SHALL cover: single request, req1 valid addr 5 data 0xDEADBEEF -> req_ready[1] = 1 same cycle, next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF.
REQ-030 Bench SHALL cover: all three valid for 6 cycles, RR_EN = 1, pointer 0 after reset -> grant order 0,1,2,0,1,2; with RR_EN = 0 -> grant 0 every cycle.
REQ-031 Bench SHALL cover: req0 valid addr 0 data 0x1234 -> handshake occurs, next cycle rf_we = 0, pointer = 1.
REQ-032 Bench SHALL cover: flush = 1 with req2 valid -> req_ready = 0, next cycle rf_we = 0; flush drops, req2 granted next cycle.
REQ-033 Bench SHALL cover: rst asserted the cycle after a handshake to addr 7 -> rf_we = 0, rf_waddr = 0, pointer = 0 after the edge.
REQ-034 Bench SHALL cover: bypass defined, rf_we = 1, rf_waddr = 3, rf_wdata = 0xA5A5A5A5, raddr1 = 3, rf_rdata1 = 0 -> fwd_rdata1 = 0xA5A5A5A5; raddr1 = 0 -> fwd_rdata1 = rf_rdata1; undefined -> fwd_rdata1 = 0.
